// File: rtl/spi_cmd_sequencer_pkg.sv
// spi_cmd_sequencer_pkg: shared opcodes, state encodings and header field positions
package spi_cmd_sequencer_pkg;
    typedef enum logic [3:0] {OP_NOP = 4'd0, OP_WRITE = 4'd1, OP_START = 4'd2} cmd_op_t;
    typedef logic [1:0] seq_state_t;
    localparam seq_state_t S_IDLE        = 2'd0;
    localparam seq_state_t S_DATA        = 2'd1;
    localparam seq_state_t S_WAIT_RENDER = 2'd2;
    localparam int OP_HI  = 63;
    localparam int OP_LO  = 60;
    localparam int CNT_HI = 59;
    localparam int CNT_LO = 52;
endpackage

// File: rtl/spi_cmd_sequencer_word_fifo.sv
// word_fifo: synchronous FIFO with full/empty/count and async active-high reset
module word_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign rdata = mem[rd_ptr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    // pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: decodes SPI command words, streams scene writes, gates render frames
module spi_cmd_sequencer
    import spi_cmd_sequencer_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_dv,
    input  logic [63:0]       in_word,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic              render_start,
    input  logic              render_done,
    output logic              irq,
    output logic              busy,
    output logic              err_opcode,
    output logic              err_overflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] IRQ_TH = CW'(FIFO_DEPTH - 1);
    seq_state_t state;
    logic [63:0] head;
    logic [CW-1:0] count;
    logic full, empty, pop, push;
    logic [ADDR_W-1:0] addr;
    logic [7:0] remaining;
    logic [3:0] op;
    assign pop  = (state != S_WAIT_RENDER) && !empty;
    assign push = in_dv && (!full || pop);
    assign op   = head[OP_HI:OP_LO];

    word_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_word),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // FSM, address counter, registered outputs and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            addr         <= '0;
            remaining    <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            render_start <= 1'b0;
            irq          <= 1'b0;
            busy         <= 1'b0;
            err_opcode   <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            mem_we       <= 1'b0;
            render_start <= 1'b0;
            irq          <= (count >= IRQ_TH) || (state == S_WAIT_RENDER);
            busy         <= state != S_IDLE;
            if (in_dv && full && !pop) err_overflow <= 1'b1;
            if (pop && state == S_DATA) begin
                mem_we    <= 1'b1;
                mem_addr  <= addr;
                mem_wdata <= head;
                addr      <= addr + ADDR_W'(1);
                remaining <= remaining - 8'd1;
                if (remaining == 8'd1) state <= S_IDLE;
            end else if (pop) begin
                if (op == OP_WRITE && head[CNT_HI:CNT_LO] != 8'd0) begin
                    addr      <= head[ADDR_W-1:0];
                    remaining <= head[CNT_HI:CNT_LO];
                    state     <= S_DATA;
                end else if (op == OP_START) begin
                    render_start <= 1'b1;
                    state        <= S_WAIT_RENDER;
                end else if (op != OP_WRITE && op != OP_NOP) begin
                    err_opcode <= 1'b1;
                end
            end
            if (state == S_WAIT_RENDER && render_done) state <= S_IDLE;
        end
    end
endmodule
